// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared types and constants for the seven-segment output path.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         DP_BIT    = 7;

    // Segment order gfedcba, indexed by nibble value
    localparam logic [6:0] c_hex_font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_font.sv
`default_nettype none
// ============================================================================
//  Module   : seg_hex_font
//  Purpose  : Combinational 4-bit nibble to 7-segment (gfedcba) decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segs
);

    assign o_segs = c_hex_font[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg_digit_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : seg_digit_scroller
//  Purpose  : Scrolls a latched word across one seven-segment display as hex
//             digits, MSD first, with per-digit dwell and blank gap.
//             Optional: SEG_LEADING_ZERO_SUPPRESS_EN skips leading zero digits.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_digit_scroller
    import seg_pkg::*;
#(
    parameter int  DATA_W       = 16,
    parameter int  DWELL_CYCLES = 5000000,
    parameter int  GAP_CYCLES   = 500000,
    parameter int  CNT_W        = 24,
    localparam int NDIG         = DATA_W / 4,
    localparam int IDX_W        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [7:0]        seg_out,
    output logic              busy,
    output logic [IDX_W-1:0]  digit_idx
);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_top_idx    = IDX_W'(NDIG - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_timer;
    logic [CNT_W-1:0]    w_timer_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    w_start_idx;
    logic [3:0]          w_nibble;
    logic [6:0]          w_font;

    always_comb begin
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
        // Highest nonzero nibble wins; an all-zero word falls back to index 0
        w_start_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (in_data[4*i +: 4] != 4'h0) begin
                w_start_idx = IDX_W'(i);
            end
        end
`else
        w_start_idx = c_top_idx;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_idx_nxt   = w_start_idx;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (r_timer == c_dwell_last) begin
                    w_timer_nxt = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                    end else if (r_idx == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            GAP: begin
                if (r_timer == c_gap_last) begin
                    w_timer_nxt = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt   = r_idx - 1'b1;
                        w_state_nxt = SHOW;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_data[4*i +: 4];
            end
        end
    end

    seg_hex_font u_font (
        .i_nibble (w_nibble),
        .o_segs   (w_font)
    );

    always_comb begin
        seg_out = SEG_BLANK;
        if (r_state == SHOW) begin
            seg_out[6:0]    = w_font;
            seg_out[DP_BIT] = (r_idx == '0);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign digit_idx = r_idx;

endmodule
`default_nettype wire
